// File: rtl/spi_mem_if.sv
// Request/response bundle between the control unit and spi_mem_ctrl.
// Carries start/done, the op selects, addr, wdata, busy and rdata.
interface spi_mem_if;
    logic        start;
    logic        rom_rd;
    logic        ram_rd;
    logic        ram_wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        done;
    logic        busy;
    logic [7:0]  rdata;

    modport master (
        output start, rom_rd, ram_rd, ram_wr, addr, wdata,
        input  done, busy, rdata
    );

    modport slave (
        input  start, rom_rd, ram_rd, ram_wr, addr, wdata,
        output done, busy, rdata
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI master (mode 0) for flash reads and SRAM reads/writes.
// Ports: clk, rst_n, bus (spi_mem_if.slave), sclk, mosi, miso, flash_cs_n, ram_cs_n.
module spi_mem_ctrl #(
    parameter int         CLK_DIV     = 1,
    parameter logic [7:0] ROM_ADDR_HI = 8'h00,
    parameter logic [7:0] ROM_RD_CMD  = 8'h03,
    parameter logic [7:0] RAM_RD_CMD  = 8'h03,
    parameter logic [7:0] RAM_WR_CMD  = 8'h02
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_mem_if.slave  bus,
    output logic      sclk,
    output logic      mosi,
    input  logic      miso,
    output logic      flash_cs_n,
    output logic      ram_cs_n
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic [5:0]    last_q, last_d;
    logic          is_rd_q, is_rd_d;
    logic [39:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          fcs_q, fcs_d;
    logic          rcs_q, rcs_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        last_d  = last_q;
        is_rd_d = is_rd_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        fcs_d   = fcs_q;
        rcs_d   = rcs_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    // Frames are left-aligned in a 40-bit shifter; unused
                    // tail bits are zero so mosi idles low on read data.
                    if (bus.ram_wr) begin
                        tx_d    = {RAM_WR_CMD, bus.addr, bus.wdata, 8'h00};
                        last_d  = 6'd31;
                        is_rd_d = 1'b0;
                        rcs_d   = 1'b0;
                    end else if (bus.ram_rd) begin
                        tx_d    = {RAM_RD_CMD, bus.addr, 16'h0000};
                        last_d  = 6'd31;
                        is_rd_d = 1'b1;
                        rcs_d   = 1'b0;
                    end else if (bus.rom_rd) begin
                        tx_d    = {ROM_RD_CMD, ROM_ADDR_HI, bus.addr, 8'h00};
                        last_d  = 6'd39;
                        is_rd_d = 1'b1;
                        fcs_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                    mosi_d = (state_d == SETUP) & tx_d[39];
                end
            end
            SETUP: state_d = SHIFT;
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == last_q) begin
                            state_d = HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + 6'd1;
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[38];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = DONE;
                fcs_d   = 1'b1;
                rcs_d   = 1'b1;
                done_d  = 1'b1;
                if (is_rd_q) rdata_d = rx_q;
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            last_q  <= '0;
            is_rd_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            fcs_q   <= 1'b1;
            rcs_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            is_rd_q <= is_rd_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            fcs_q   <= fcs_d;
            rcs_q   <= rcs_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.rdata  = rdata_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign flash_cs_n = fcs_q;
    assign ram_cs_n   = rcs_q;

endmodule
